// File: rtl/uart_tx_packer.sv
// uart_tx_packer: byte FIFO that packs sz bytes into one uart frame.
// Ports: osc/rst clock and async reset; wr_data/wr_en byte input;
//   flush sends a short padded frame; tx_busy from the uart;
//   tx_data[sz]/en_tx frame handoff; full/empty/ovf FIFO status;
//   frames counts frames the uart has finished.
module uart_tx_packer #(
  parameter int         sz    = 4,
  parameter int         DEPTH = 16,
  parameter logic [7:0] PAD   = 8'h00
) (
  input  logic        osc,
  input  logic        rst,
  input  logic [7:0]  wr_data,
  input  logic        wr_en,
  input  logic        flush,
  input  logic        tx_busy,
  output logic [7:0]  tx_data [sz],
  output logic        en_tx,
  output logic        full,
  output logic        empty,
  output logic        ovf,
  output logic [15:0] frames
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int IW = (sz > 1) ? $clog2(sz + 1) : 1;

  localparam logic [CW-1:0] DEPTHC = CW'(DEPTH);
  localparam logic [CW-1:0] SZC    = CW'(sz);
  localparam logic [AW-1:0] LASTP  = AW'(DEPTH - 1);
  localparam logic [IW-1:0] SZI    = IW'(sz);
  localparam logic [IW-1:0] LASTI  = IW'(sz - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    START,
    BUSY
  } state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [IW-1:0] n;
  logic          push;
  logic          pop;
  logic [7:0]    rd;

  // Pops happen only while loading real slots; pad slots pop nothing.
  assign pop   = (state == LOAD) && (idx < n);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push  = wr_en && (!full || pop);
  assign full  = (cnt == DEPTHC);
  assign empty = (cnt == '0);
  assign rd    = mem[rp];

  always_ff @(posedge osc) begin
    if (push) begin
      mem[wp] <= wr_data;
    end
  end

  always_ff @(posedge osc or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (push) begin
        wp <= (wp == LASTP) ? '0 : wp + 1'b1;
      end
      if (pop) begin
        rp <= (rp == LASTP) ? '0 : rp + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (wr_en && !push) begin
        ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge osc or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      en_tx  <= 1'b0;
      idx    <= '0;
      n      <= '0;
      frames <= '0;
      for (int i = 0; i < sz; i++) begin
        tx_data[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (!tx_busy && cnt >= SZC) begin
            n     <= SZI;
            idx   <= '0;
            state <= LOAD;
          end else if (!tx_busy && flush && !empty) begin
            n     <= IW'(cnt);
            idx   <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          for (int i = 0; i < sz; i++) begin
            if (idx == IW'(i)) begin
              tx_data[i] <= pop ? rd : PAD;
            end
          end
          idx <= idx + 1'b1;
          // en_tx rises with the last slot so the frame is whole.
          if (idx == LASTI) begin
            en_tx <= 1'b1;
            state <= START;
          end
        end
        START: begin
          if (tx_busy) begin
            en_tx <= 1'b0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (!tx_busy) begin
            frames <= frames + 16'd1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_packer.sv
// tb_uart_tx_packer: scoreboard bench for uart_tx_packer.
// Bytes go into a queue when pushed; frames are checked on en_tx.
module tb_uart_tx_packer;

  localparam int SZ = 4;

  logic        osc;
  logic        rst;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        flush;
  logic        tx_busy;
  logic [7:0]  tx_data [SZ];
  logic        en_tx;
  logic        full;
  logic        empty;
  logic        ovf;
  logic [15:0] frames;

  int total = 0;
  int bad = 0;
  int seen = 0;
  int mw = 0;
  int mb = 0;
  bit model_on = 0;
  bit rise_pend = 0;
  bit prev_en = 0;
  logic [7:0] q [$];

  uart_tx_packer #(.sz(SZ), .DEPTH(16), .PAD(8'h00)) dut (
    .osc     (osc),
    .rst     (rst),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .flush   (flush),
    .tx_busy (tx_busy),
    .tx_data (tx_data),
    .en_tx   (en_tx),
    .full    (full),
    .empty   (empty),
    .ovf     (ovf),
    .frames  (frames)
  );

  initial begin
    osc = 0;
    forever #5 osc = ~osc;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Frame monitor and uart model share one process to avoid races.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge osc);
      if (rise_pend) begin
        chk("en_fall", en_tx, 0);
        rise_pend = 0;
      end
      if (en_tx && !prev_en) begin
        chk("busy_at_en", tx_busy, 0);
        seen++;
        for (int i = 0; i < SZ; i++) begin
          chk("q_avail", q.size() > 0, 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            chk($sformatf("byte%0d", i), tx_data[i], e);
          end
        end
      end
      prev_en = en_tx;
      if (model_on) begin
        if (mb > 0) begin
          mb--;
          if (mb == 0) tx_busy = 0;
        end else if (mw > 0) begin
          mw--;
          if (mw == 0) begin
            tx_busy = 1;
            mb = 20;
            rise_pend = 1;
          end
        end else if (en_tx && !tx_busy) begin
          mw = 3;
        end
      end
    end
  end

  task automatic push(input logic [7:0] b, input bit waitfull);
    int k = 0;
    while (waitfull && full && k < 500) begin
      @(negedge osc);
      k++;
    end
    if (waitfull) chk("push_wait", k < 500, 1);
    if (!full) q.push_back(b);
    wr_data = b;
    wr_en = 1;
    @(negedge osc);
    wr_en = 0;
  endtask

  task automatic wait_idle();
    int k = 0;
    int s = 0;
    while (s < 4 && k < 3000) begin
      @(negedge osc);
      k++;
      if (q.size() == 0 && !en_tx && !tx_busy &&
          mw == 0 && mb == 0 && empty) s++;
      else s = 0;
    end
    chk("idle", s >= 4, 1);
  endtask

  task automatic do_reset();
    @(negedge osc);
    rst = 1;
    repeat (2) @(negedge osc);
    rst = 0;
    q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=done");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int s0;
    rst = 1;
    wr_en = 0;
    wr_data = 0;
    flush = 0;
    tx_busy = 0;
    repeat (2) @(negedge osc);
    chk("rst_en", en_tx, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ovf", ovf, 0);
    chk("rst_frames", frames, 0);
    chk("rst_d0", tx_data[0], 0);
    chk("rst_d3", tx_data[3], 0);
    rst = 0;
    model_on = 1;

    for (int i = 0; i < 4; i++) push(8'h31 + 8'(i), 1);
    lat = 0;
    while (!en_tx && lat < 50) begin
      @(negedge osc);
      lat++;
    end
    chk("latency", lat, SZ + 1);
    wait_idle();
    chk("f1_frames", frames, 1);
    chk("f1_hold0", tx_data[0], 8'h31);
    chk("f1_hold3", tx_data[3], 8'h34);

    for (int i = 0; i < 8; i++) push(8'h31 + 8'(i), 1);
    wait_idle();
    chk("b2b_frames", frames, 3);
    chk("b2b_seen", seen, 3);

    push(8'hA0, 1);
    push(8'hA1, 1);
    repeat (3) @(negedge osc);
    chk("fl_pre_empty", empty, 0);
    chk("fl_no_en", en_tx, 0);
    q.push_back(8'h00);
    q.push_back(8'h00);
    flush = 1;
    @(negedge osc);
    flush = 0;
    wait_idle();
    chk("fl_frames", frames, 4);
    chk("fl_empty", empty, 1);
    s0 = seen;
    flush = 1;
    @(negedge osc);
    flush = 0;
    repeat (40) @(negedge osc);
    chk("fl0_frames", frames, 4);
    chk("fl0_seen", seen, s0);

    model_on = 0;
    tx_busy = 1;
    for (int i = 0; i < 17; i++) begin
      push(8'h60 + 8'(i), 0);
      if (i == 15) begin
        chk("ov_full16", full, 1);
        chk("ov_ovf16", ovf, 0);
      end
    end
    chk("ov_ovf17", ovf, 1);
    chk("ov_full17", full, 1);
    chk("ov_q", q.size(), 16);
    tx_busy = 0;
    model_on = 1;
    wait_idle();
    chk("ov_frames", frames, 8);
    chk("ov_sticky", ovf, 1);

    model_on = 0;
    tx_busy = 0;
    for (int i = 0; i < 4; i++) push(8'h51 + 8'(i), 1);
    lat = 0;
    while (!en_tx && lat < 50) begin
      @(negedge osc);
      lat++;
    end
    chk("rs_en_up", en_tx, 1);
    #2;
    rst = 1;
    #1;
    chk("rs_en", en_tx, 0);
    chk("rs_empty", empty, 1);
    chk("rs_frames", frames, 0);
    chk("rs_ovf", ovf, 0);
    @(negedge osc);
    rst = 0;
    q.delete();
    model_on = 1;
    for (int i = 0; i < 4; i++) push(8'h41 + 8'(i), 1);
    wait_idle();
    chk("rs2_frames", frames, 1);
    chk("rs2_d0", tx_data[0], 8'h41);
    chk("rs2_d3", tx_data[3], 8'h44);

    do_reset();
    s0 = seen;
    for (int i = 0; i < 40; i++) push(8'(i), 1);
    wait_idle();
    chk("wr_frames", frames, 10);
    chk("wr_seen", seen - s0, 10);
    chk("wr_ovf", ovf, 0);
    chk("wr_q", q.size(), 0);
    chk("wr_d3", tx_data[3], 8'h27);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
